// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// axi4_lite_pkg -- shared AXI4-lite response codes, command-master states and defaults (rev 1.0).
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } cmd_master_state_t;

  localparam logic [2:0] DEFAULT_PROT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/ifc_axi4_lite.sv
`default_nettype none
// ifc_axi4_lite -- AXI4-lite bundle with master and slave views (rev 1.0).
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// axi4_lite_cmd_master -- valid/ready command stream to single AXI4-lite transactions (rev 1.0).
// Define AXI4_LITE_CMD_MASTER_STRB_EN to add the i_cmd_wstrb byte-strobe input.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  ifc_axi4_lite.master                if_axi,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
`ifdef AXI4_LITE_CMD_MASTER_STRB_EN
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
`endif
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_busy
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  generate
    if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi4_lite_cmd_master: AXI_DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  cmd_master_state_t         state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0]     wstrb;
  logic                      awvalid;
  logic                      wvalid;
  logic                      bready;
  logic                      arvalid;
  logic                      rready;
  logic                      rsp_valid;
  logic                      rsp_write;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata;
  resp_t                     rsp_resp;
  logic                      aw_done;
  logic                      w_done;

  // A channel whose valid already dropped has completed its handshake.
  assign aw_done = !awvalid || if_axi.awready;
  assign w_done  = !wvalid  || if_axi.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            addr  <= i_cmd_addr;
            wdata <= i_cmd_wdata;
            if (i_cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && if_axi.awready) awvalid <= 1'b0;
          if (wvalid && if_axi.wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (if_axi.bvalid) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= resp_t'(if_axi.bresp);
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (if_axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (if_axi.rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= if_axi.rdata;
            rsp_resp  <= resp_t'(if_axi.rresp);
            state     <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI4_LITE_CMD_MASTER_STRB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wstrb <= '0;
    end else if (state == IDLE && i_cmd_valid) begin
      wstrb <= i_cmd_wstrb;
    end
  end
`else
  assign wstrb = '1;
`endif

  // Held low during reset so nothing is accepted before the first clean cycle.
  assign o_cmd_ready = (state == IDLE) && !rst;
  assign o_busy      = (state != IDLE);
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_write = rsp_write;
  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_resp  = rsp_resp;

  assign if_axi.awaddr  = addr;
  assign if_axi.awprot  = DEFAULT_PROT;
  assign if_axi.awvalid = awvalid;
  assign if_axi.wdata   = wdata;
  assign if_axi.wstrb   = wstrb;
  assign if_axi.wvalid  = wvalid;
  assign if_axi.bready  = bready;
  assign if_axi.araddr  = addr;
  assign if_axi.arprot  = DEFAULT_PROT;
  assign if_axi.arvalid = arvalid;
  assign if_axi.rready  = rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_master.sv
`default_nettype none
// tb_axi4_lite_cmd_master -- directed bench with a small delay-configurable AXI4-lite register slave.
module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = 4'hF;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;

  always #5 clk = ~clk;

  ifc_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_cmd_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_axi      (axi),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
`ifdef AXI4_LITE_CMD_MASTER_STRB_EN
    .i_cmd_wstrb (cmd_wstrb),
`endif
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_write (rsp_write),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
    .o_busy      (busy)
  );

  // ---------------- slave model: 16 word registers at 0x00..0x3C ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic        got_aw, got_w, got_ar;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;
  logic [31:0] mem [0:15];

  assign axi.awready = axi.awvalid && (aw_wait >= aw_dly);
  assign axi.wready  = axi.wvalid  && (w_wait  >= w_dly);
  assign axi.bvalid  = got_aw && got_w && (b_wait >= b_dly);
  assign axi.bresp   = (wr_addr < 32'h40) ? 2'b00 : 2'b10;
  assign axi.arready = axi.arvalid && (ar_wait >= ar_dly);
  assign axi.rvalid  = got_ar && (r_wait >= r_dly);
  assign axi.rdata   = (rd_addr < 32'h40) ? mem[rd_addr[5:2]] : 32'hDEC0_DEC0;
  assign axi.rresp   = (rd_addr < 32'h40) ? 2'b00 : 2'b11;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
      wr_addr <= '0; wr_data <= '0; wr_strb <= '0; rd_addr <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
      w_wait  <= (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
      b_wait  <= (got_aw && got_w && !axi.bvalid) ? b_wait + 1 : 0;
      ar_wait <= (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;
      r_wait  <= (got_ar && !axi.rvalid) ? r_wait + 1 : 0;
      if (axi.awvalid && axi.awready) begin got_aw <= 1'b1; wr_addr <= axi.awaddr; end
      if (axi.wvalid && axi.wready) begin got_w <= 1'b1; wr_data <= axi.wdata; wr_strb <= axi.wstrb; end
      if (axi.bvalid && axi.bready) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        if (wr_addr < 32'h40)
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
      if (axi.arvalid && axi.arready) begin got_ar <= 1'b1; rd_addr <= axi.araddr; end
      if (axi.rvalid && axi.rready) got_ar <= 1'b0;
    end
  end

  // ---------------- monitors: cycle stamps, handshake counts, stability ----------------
  int cyc = 0, acc_cyc = 0, rsp_hs_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, stab_viol = 0;
  logic [3:0]  last_wstrb = '0;
  logic        aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
  logic [31:0] aw_val, w_val, ar_val;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_cyc <= cyc;
      if (rsp_valid && rsp_ready) rsp_hs_cyc <= cyc;
      if (axi.awvalid && axi.awready) begin aw_cnt <= aw_cnt + 1; aw_hs_cyc <= cyc; end
      if (axi.wvalid && axi.wready) begin w_cnt <= w_cnt + 1; w_hs_cyc <= cyc; last_wstrb <= axi.wstrb; end
      if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
      if ((aw_hold && (!axi.awvalid || axi.awaddr != aw_val)) ||
          (w_hold && (!axi.wvalid || axi.wdata != w_val)) ||
          (ar_hold && (!axi.arvalid || axi.araddr != ar_val)))
        stab_viol <= stab_viol + 1;
      aw_hold <= axi.awvalid && !axi.awready; aw_val <= axi.awaddr;
      w_hold  <= axi.wvalid && !axi.wready;   w_val  <= axi.wdata;
      ar_hold <= axi.arvalid && !axi.arready; ar_val <= axi.araddr;
    end else begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with rsp_ready low; returns after the response handshake.
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic rw, inout int lat);
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // lat counts cycles from acceptance (cycle 0) to the first cycle o_rsp_valid is seen.
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic [1:0] rs, output logic rw, output int lat);
    int n;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) check("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    wait_rsp(rd, rs, rw, lat);
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic        rw;
  int          lat, a0, w0, b0, n, bad;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    check("rst_rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // zero-wait write 0x08 <- 0xDEADBEEF
    do_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, rd, rs, rw, lat);
    check("wr_latency", lat, 3);
    check("wr_aw_hs_cycle", aw_hs_cyc - acc_cyc, 1);
    check("wr_w_hs_cycle", w_hs_cyc - acc_cyc, 1);
    check("wr_rsp", {rw, rs, rd}, {1'b1, 2'b00, 32'h0});
    check("wr_wstrb", last_wstrb, 4'hF);
    check("wr_mem2", mem[2], 32'hDEAD_BEEF);
    check("wr_idle", {busy, cmd_ready}, 2'b01);

    // delayed read of 0x08
    ar_dly = 3; r_dly = 2;
    do_cmd(1'b0, 32'h8, 32'h0, 4'hF, rd, rs, rw, lat);
    check("rd_latency", lat, 8);
    check("rd_rsp", {rw, rs, rd}, {1'b0, 2'b00, 32'hDEAD_BEEF});
    ar_dly = 0; r_dly = 0;

    // write ordering: W early, AW early, simultaneous
    aw_dly = 4; w_dly = 0; a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_cmd(1'b1, 32'hC, 32'h1111_0001, 4'hF, rd, rs, rw, lat);
    check("wr_w_first_hs", {aw_cnt - a0, w_cnt - w0, b_cnt - b0, 30'(rs)}, {32'd1, 32'd1, 32'd1, 30'd0});
    check("wr_w_first_mem", mem[3], 32'h1111_0001);
    aw_dly = 0; w_dly = 4; a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_cmd(1'b1, 32'h10, 32'h2222_0002, 4'hF, rd, rs, rw, lat);
    check("wr_aw_first_hs", {aw_cnt - a0, w_cnt - w0, b_cnt - b0, 30'(rs)}, {32'd1, 32'd1, 32'd1, 30'd0});
    check("wr_aw_first_mem", mem[4], 32'h2222_0002);
    aw_dly = 2; w_dly = 2; a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_cmd(1'b1, 32'h14, 32'h3333_0003, 4'hF, rd, rs, rw, lat);
    check("wr_same_hs", {aw_cnt - a0, w_cnt - w0, b_cnt - b0, 30'(rs)}, {32'd1, 32'd1, 32'd1, 30'd0});
    check("wr_same_mem", mem[5], 32'h3333_0003);
    aw_dly = 0; w_dly = 0;

    // out-of-range read returning DECERR
    do_cmd(1'b0, 32'h100, 32'h0, 4'hF, rd, rs, rw, lat);
    check("decerr_rsp", {rw, rs, rd}, {1'b0, 2'b11, 32'hDEC0_DEC0});
    check("decerr_idle", {busy, cmd_ready}, 2'b01);

    // response backpressure with a second command waiting
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h0BAD_F00D;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF ||
          rsp_write !== 1'b0 || rsp_resp !== 2'b00) bad++;
      @(negedge clk);
    end
    check("bp_rsp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after_hs", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_accept_gap", acc_cyc - rsp_hs_cyc, 1);
    lat = 1;
    wait_rsp(rd, rs, rw, lat);
    check("bp_second_wr", {rw, rs, mem[6]}, {1'b1, 2'b00, 32'h0BAD_F00D});

    // reset while waiting in WR_RESP
    b_dly = 6;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1C; cmd_wdata = 32'h5555_5555;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!axi.bready && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_in_wr_resp", {busy, axi.bready}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    b_dly = 0;
    @(negedge clk);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    check("rst_mid_idle", {busy, cmd_ready}, 2'b01);
    check("rst_mid_no_write", mem[7], 32'h0);

`ifdef AXI4_LITE_CMD_MASTER_STRB_EN
    do_cmd(1'b1, 32'h4, 32'hAAAA_AAAA, 4'hF, rd, rs, rw, lat);
    do_cmd(1'b1, 32'h4, 32'h1234_5678, 4'b0011, rd, rs, rw, lat);
    check("strb_wstrb", last_wstrb, 4'b0011);
    do_cmd(1'b0, 32'h4, 32'h0, 4'hF, rd, rs, rw, lat);
    check("strb_readback", rd, 32'hAAAA_5678);
`else
    do_cmd(1'b1, 32'h4, 32'hAAAA_5678, 4'b0011, rd, rs, rw, lat);
    check("nostrb_wstrb", last_wstrb, 4'hF);
    do_cmd(1'b0, 32'h4, 32'h0, 4'hF, rd, rs, rw, lat);
    check("nostrb_readback", rd, 32'hAAAA_5678);
`endif

    check("addr_data_stability", stab_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
